// File: rtl/gpio_control_bank.sv
// Serial-programmed configuration bank for NUM_GPIO pads with length-checked
// loads, configuration readback and per-pad management/user signal muxing.

module gpio_pad_lane (
   input  logic [12:0] cfg,
   input  logic        mgmt_out,
   input  logic        mgmt_oeb,
   input  logic        user_out,
   input  logic        user_oeb,
   output logic        outenb,
   output logic        out,
   output logic        holdover,
   output logic        slow_sel,
   output logic        vtrip_sel,
   output logic        inenb,
   output logic        ib_mode_sel,
   output logic        ana_en,
   output logic        ana_sel,
   output logic        ana_pol,
   output logic [2:0]  dm
);
   logic mgmt_en;

   assign mgmt_en     = cfg[0];
   assign holdover    = cfg[2];
   assign inenb       = cfg[3];
   assign ib_mode_sel = cfg[4];
   assign ana_en      = cfg[5];
   assign ana_sel     = cfg[6];
   assign ana_pol     = cfg[7];
   assign slow_sel    = cfg[8];
   assign vtrip_sel   = cfg[9];
   assign dm          = cfg[12:10];

   // With management driving and output disabled, a pull-type drive mode
   // (DM=01x) uses the pad output to select the pull direction.
   always_comb begin
      outenb = user_oeb;
      out    = user_out;
      if (mgmt_en) begin
         outenb = mgmt_oeb ? cfg[1] : 1'b0;
         out    = (mgmt_oeb && (dm[2:1] == 2'b01)) ? ~dm[0] : mgmt_out;
      end
   end
endmodule

module gpio_control_bank #(
   parameter int NUM_GPIO      = 4,
   parameter int PAD_CTRL_BITS = 13,
   parameter int CHAIN_LEN     = NUM_GPIO * PAD_CTRL_BITS
) (
   input  logic                  serial_clock,
   input  logic                  resetn,
   input  logic [CHAIN_LEN-1:0]  gpio_defaults,
   input  logic                  serial_shift,
   input  logic                  serial_data_in,
   input  logic                  serial_load,
   input  logic                  serial_readback,
   output logic                  serial_data_out,
   output logic                  load_error,
   input  logic                  user_power_good,
   input  logic [NUM_GPIO-1:0]   mgmt_gpio_out,
   input  logic [NUM_GPIO-1:0]   mgmt_gpio_oeb,
   output logic [NUM_GPIO-1:0]   mgmt_gpio_in,
   input  logic [NUM_GPIO-1:0]   user_gpio_out,
   input  logic [NUM_GPIO-1:0]   user_gpio_oeb,
   output logic [NUM_GPIO-1:0]   user_gpio_in,
   output logic [NUM_GPIO-1:0]   pad_gpio_holdover,
   output logic [NUM_GPIO-1:0]   pad_gpio_slow_sel,
   output logic [NUM_GPIO-1:0]   pad_gpio_vtrip_sel,
   output logic [NUM_GPIO-1:0]   pad_gpio_inenb,
   output logic [NUM_GPIO-1:0]   pad_gpio_ib_mode_sel,
   output logic [NUM_GPIO-1:0]   pad_gpio_ana_en,
   output logic [NUM_GPIO-1:0]   pad_gpio_ana_sel,
   output logic [NUM_GPIO-1:0]   pad_gpio_ana_pol,
   output logic [NUM_GPIO-1:0]   pad_gpio_outenb,
   output logic [NUM_GPIO-1:0]   pad_gpio_out,
   output logic [3*NUM_GPIO-1:0] pad_gpio_dm,
   input  logic [NUM_GPIO-1:0]   pad_gpio_in
);
   localparam int CNT_W = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0]      shift_reg;
   logic [CHAIN_LEN-1:0]      config_q;
   logic [CNT_W-1:0]          bit_count;
   logic                      load_q;
   logic                      readback_q;
   logic                      load_edge;
   logic                      readback_edge;
   logic [NUM_GPIO-1:0][2:0]  dm_lane;

   assign load_edge     = serial_load & ~load_q;
   assign readback_edge = serial_readback & ~readback_q;

   // Load beats readback beats shift; saturating the count one past full
   // keeps over-length loads distinguishable from exact ones.
   always_ff @(posedge serial_clock) begin
      if (!resetn) begin
         shift_reg       <= '0;
         serial_data_out <= 1'b0;
         bit_count       <= '0;
         load_error      <= 1'b0;
         load_q          <= 1'b0;
         readback_q      <= 1'b0;
         config_q        <= gpio_defaults;
      end else begin
         load_q          <= serial_load;
         readback_q      <= serial_readback;
         serial_data_out <= shift_reg[CHAIN_LEN-1];
         if (load_edge) begin
            bit_count <= '0;
            if (bit_count == CNT_FULL) begin
               config_q   <= shift_reg;
               load_error <= 1'b0;
            end else begin
               load_error <= 1'b1;
            end
         end else if (readback_edge) begin
            shift_reg <= config_q;
            bit_count <= '0;
         end else if (serial_shift) begin
            shift_reg <= {shift_reg[CHAIN_LEN-2:0], serial_data_in};
            if (bit_count != CNT_SAT) bit_count <= bit_count + CNT_W'(1);
         end
      end
   end

   assign mgmt_gpio_in = pad_gpio_in;
   assign user_gpio_in = pad_gpio_in & {NUM_GPIO{user_power_good}};
   assign pad_gpio_dm  = dm_lane;

   for (genvar k = 0; k < NUM_GPIO; k++) begin : g_lane
      gpio_pad_lane u_lane (
         .cfg         (config_q[k*PAD_CTRL_BITS +: 13]),
         .mgmt_out    (mgmt_gpio_out[k]),
         .mgmt_oeb    (mgmt_gpio_oeb[k]),
         .user_out    (user_gpio_out[k]),
         .user_oeb    (user_gpio_oeb[k]),
         .outenb      (pad_gpio_outenb[k]),
         .out         (pad_gpio_out[k]),
         .holdover    (pad_gpio_holdover[k]),
         .slow_sel    (pad_gpio_slow_sel[k]),
         .vtrip_sel   (pad_gpio_vtrip_sel[k]),
         .inenb       (pad_gpio_inenb[k]),
         .ib_mode_sel (pad_gpio_ib_mode_sel[k]),
         .ana_en      (pad_gpio_ana_en[k]),
         .ana_sel     (pad_gpio_ana_sel[k]),
         .ana_pol     (pad_gpio_ana_pol[k]),
         .dm          (dm_lane[k])
      );
   end
endmodule
